// File: rtl/pico_isa_pkg.sv
// Shared definitions for the pico instruction path: opcodes, field positions
// and sequencer state encodings.
package pico_isa_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    IMM  = 2'd1,
    MULT = 2'd2,
    BRAN = 2'd3
  } opcode_e;

  // opcode sits in the top OPC_W bits; the branch offset starts at OFF_LSB
  localparam int OPC_W   = 2;
  localparam int OFF_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_STALL = 3'd3,
    S_HALT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pc_target.sv
// Next-PC arithmetic: sequential increment and sign-extended branch target,
// both wrapping modulo 2^PC_W.
module pc_target #(
  parameter int PC_W  = 8,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  seq_base,
  input  logic [PC_W-1:0]  bran_base,
  input  logic [OFF_W-1:0] offset,
  input  logic             take,
  output logic [PC_W-1:0]  seq_pc,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] bran_pc;

  assign off_ext = PC_W'($signed(offset));
  assign seq_pc  = seq_base + PC_W'(1);
  assign bran_pc = bran_base + off_ext;
  assign next_pc = take ? bran_pc : seq_pc;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue sequencer: owns the PC, fetches from a 1-cycle-latency program
// memory and redirects or stalls on decoder flags. Define SELF_LOOP_HALT_EN to
// turn a taken zero-offset branch into a permanent HALT.
//
//   state | meaning
//   IDLE  | stopped, fetch_pc held, waiting for run
//   PRIME | fetch issued, memory word not yet valid (also branch bubble)
//   RUN   | instr_out live, one retire per cycle
//   STALL | waiting for mult_done, PCs held
//   HALT  | self-loop reached, frozen until reset (macro builds only)
module instr_sequencer
  import pico_isa_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24,
  parameter int OFF_W   = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [1:0]         opcode,
  output logic               instr_valid,
  output logic               instr_retire,
  output logic [PC_W-1:0]    issue_pc,
  input  logic               bran_in,
  input  logic               bran_cond,
  input  logic               mult_flag_in,
  input  logic               mult_done,
  output logic               stall,
  output logic               halted
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_PRIME = S_PRIME;
  localparam logic [2:0] ST_RUN   = S_RUN;
  localparam logic [2:0] ST_STALL = S_STALL;
`ifdef SELF_LOOP_HALT_EN
  localparam logic [2:0] ST_HALT  = S_HALT;
`endif

  logic [2:0]       state, state_nxt;
  logic [PC_W-1:0]  fetch_pc, fetch_nxt, issue_nxt;
  logic [PC_W-1:0]  seq_pc, next_pc;
  logic [OFF_W-1:0] offset;
  logic             mult_wait, take_branch, retire;

  assign instr_out = imem_rdata;
  assign opcode    = imem_rdata[INSTR_W-1 -: OPC_W];
  assign offset    = imem_rdata[OFF_LSB +: OFF_W];
  assign imem_addr = fetch_pc;

  assign mult_wait   = mult_flag_in & ~mult_done;
  assign take_branch = (state == ST_RUN) & ~mult_wait & bran_in & bran_cond;

  pc_target #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_target (
    .seq_base  (fetch_pc),
    .bran_base (issue_pc),
    .offset    (offset),
    .take      (take_branch),
    .seq_pc    (seq_pc),
    .next_pc   (next_pc)
  );

  // When run drops, fetch_pc keeps the address of the next instruction so
  // PRIME can re-fetch it on restart.
  always_comb begin
    state_nxt = state;
    fetch_nxt = fetch_pc;
    issue_nxt = issue_pc;
    retire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        issue_nxt = fetch_pc;
        fetch_nxt = seq_pc;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (mult_wait) begin
          state_nxt = ST_STALL;
        end else if (take_branch) begin
          retire = 1'b1;
`ifdef SELF_LOOP_HALT_EN
          if (offset == '0) begin
            state_nxt = ST_HALT;
          end else begin
            fetch_nxt = next_pc;
            state_nxt = run ? ST_PRIME : ST_IDLE;
          end
`else
          fetch_nxt = next_pc;
          state_nxt = run ? ST_PRIME : ST_IDLE;
`endif
        end else begin
          retire    = 1'b1;
          issue_nxt = fetch_pc;
          fetch_nxt = run ? seq_pc : fetch_pc;
          state_nxt = run ? ST_RUN : ST_IDLE;
        end
      end
      ST_STALL: begin
        if (mult_done) begin
          retire    = 1'b1;
          issue_nxt = fetch_pc;
          fetch_nxt = run ? seq_pc : fetch_pc;
          state_nxt = run ? ST_RUN : ST_IDLE;
        end
      end
`ifdef SELF_LOOP_HALT_EN
      ST_HALT: state_nxt = ST_HALT;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      fetch_pc <= '0;
      issue_pc <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_nxt;
      issue_pc <= issue_nxt;
    end
  end

  assign instr_valid  = (state == ST_RUN) | (state == ST_STALL);
  assign instr_retire = retire;
  assign stall        = (state == ST_STALL);
`ifdef SELF_LOOP_HALT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
